// File: rtl/lambert_shade_stream.sv
// Lambertian diffuse shader: per-pixel N.L with ambient term, scales a fixed
// base colour to RGB888 and emits an AXI4-Stream video beat stream with
// start-of-frame (tuser) and end-of-line (tlast) markers.
// Three register stages advance in lock-step under a single enable.
module lambert_shade_stream #(
   parameter int          H_RES    = 640,
   parameter int          V_RES    = 480,
   parameter logic [31:0] AMBIENT  = 32'h00400000,
   parameter logic [31:0] KD       = 32'h00C00000,
   parameter logic [23:0] BASE_RGB = 24'hFF8040,
   parameter logic [23:0] BG_RGB   = 24'h000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid_in,
   output logic        ready_in,
   input  logic        hit,
   input  logic [95:0] surfaceNormal,
   input  logic [95:0] surfaceLightVector,
   output logic [23:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tuser,
   output logic        m_axis_tlast
);

   localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);
   localparam logic signed [33:0] ONE34 = 34'sh1000000;

   // Q8.24 multiply: full signed product, keep bits [55:24] (floors toward -inf)
   function automatic logic signed [31:0] fp_mul(input logic signed [31:0] a,
                                                 input logic signed [31:0] b);
      logic signed [63:0] p;
      p = 64'(a) * 64'(b);
      return 32'(p >>> 24);
   endfunction

   // 8-bit colour channel times intensity in [0,1.0]; 1.0 returns the channel unchanged
   function automatic logic [7:0] chan_scale(input logic [7:0] c, input logic [24:0] i);
      logic [32:0] p;
      p = 33'(c) * 33'(i);
      return 8'(p >> 24);
   endfunction

   // stage 1: per-axis products
   logic               s1_valid_q, s1_valid_d;
   logic               s1_hit_q, s1_hit_d;
   logic signed [31:0] s1_prod_q [3];
   logic signed [31:0] s1_prod_d [3];
   // stage 2: clamped intensity
   logic               s2_valid_q, s2_valid_d;
   logic               s2_hit_q, s2_hit_d;
   logic [24:0]        s2_inten_q, s2_inten_d;
   // stage 3: output beat
   logic               tvalid_q, tvalid_d;
   logic [23:0]        tdata_q, tdata_d;
   // position of the beat currently presented on the output
   logic [XW-1:0]      x_q, x_d;
   logic [YW-1:0]      y_q, y_d;

   logic               en;
   logic signed [33:0] dot_sum;
   logic signed [31:0] diff_clamped;
   logic signed [33:0] inten_sum;
   logic [23:0]        shaded_rgb;

   // whole pipeline moves only when the output register is free or being drained
   assign en       = !tvalid_q || m_axis_tready;
   assign ready_in = rst_n && en;

   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tdata  = tdata_q;
   assign m_axis_tuser  = tvalid_q && (x_q == '0) && (y_q == '0);
   assign m_axis_tlast  = tvalid_q && (x_q == X_LAST);

   // datapath arithmetic feeding stages 2 and 3
   always_comb begin
      dot_sum = 34'(s1_prod_q[0]) + 34'(s1_prod_q[1]) + 34'(s1_prod_q[2]);
      diff_clamped = '0;
      if (dot_sum < 0)
         diff_clamped = '0;
      else if (dot_sum > ONE34)
         diff_clamped = 32'sh01000000;
      else
         diff_clamped = 32'(dot_sum);
      inten_sum = 34'($signed(AMBIENT)) + 34'(fp_mul($signed(KD), diff_clamped));
      for (int c = 0; c < 3; c++)
         shaded_rgb[c*8 +: 8] = chan_scale(BASE_RGB[c*8 +: 8], s2_inten_q);
   end

   // next-state for all stages and the beat position counters
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_hit_d   = s1_hit_q;
      s1_prod_d  = s1_prod_q;
      s2_valid_d = s2_valid_q;
      s2_hit_d   = s2_hit_q;
      s2_inten_d = s2_inten_q;
      tvalid_d   = tvalid_q;
      tdata_d    = tdata_q;
      x_d        = x_q;
      y_d        = y_q;

      if (en) begin
         s1_valid_d = valid_in;
         s1_hit_d   = hit;
         for (int i = 0; i < 3; i++)
            s1_prod_d[i] = fp_mul(surfaceNormal[i*32 +: 32], surfaceLightVector[i*32 +: 32]);

         s2_valid_d = s1_valid_q;
         s2_hit_d   = s1_hit_q;
         if (inten_sum < 0)
            s2_inten_d = '0;
         else if (inten_sum > ONE34)
            s2_inten_d = 25'h1000000;
         else
            s2_inten_d = 25'(inten_sum);

         tvalid_d = s2_valid_q;
         if (s2_valid_q)
            tdata_d = s2_hit_q ? shaded_rgb : BG_RGB;
      end

      // counters follow accepted beats only, so bubbles and stalls leave them alone
      if (tvalid_q && m_axis_tready) begin
         if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   // state registers; reset discards anything in flight and restarts the frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_hit_q   <= 1'b0;
         for (int i = 0; i < 3; i++)
            s1_prod_q[i] <= '0;
         s2_valid_q <= 1'b0;
         s2_hit_q   <= 1'b0;
         s2_inten_q <= '0;
         tvalid_q   <= 1'b0;
         tdata_q    <= '0;
         x_q        <= '0;
         y_q        <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_hit_q   <= s1_hit_d;
         s1_prod_q  <= s1_prod_d;
         s2_valid_q <= s2_valid_d;
         s2_hit_q   <= s2_hit_d;
         s2_inten_q <= s2_inten_d;
         tvalid_q   <= tvalid_d;
         tdata_q    <= tdata_d;
         x_q        <= x_d;
         y_q        <= y_d;
      end
   end

endmodule

// File: tb/tb_lambert_shade_stream.sv
// Self-checking bench for lambert_shade_stream with a small 4x2 frame.
// Expected colours are queued at input acceptance and compared at output handshake.
module tb_lambert_shade_stream;

   localparam int H = 4;
   localparam int V = 2;
   localparam logic [31:0] ONE = 32'h01000000;
   localparam logic [31:0] NEG = 32'hFF000000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_in = 1'b0;
   logic        hit = 1'b0;
   logic [95:0] surfaceNormal = '0;
   logic [95:0] surfaceLightVector = '0;
   logic        m_axis_tready = 1'b0;
   logic        ready_in;
   logic [23:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tuser;
   logic        m_axis_tlast;

   logic [23:0] exp_in = '0;
   int          compared = 0;
   int          mismatched = 0;
   logic [23:0] sb_q[$];
   int          bx = 0;
   int          by = 0;

   logic [95:0] pn [16];
   logic [95:0] pl [16];
   logic        ph [16];
   logic [23:0] pe [16];

   lambert_shade_stream #(.H_RES(H), .V_RES(V)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .valid_in           (valid_in),
      .ready_in           (ready_in),
      .hit                (hit),
      .surfaceNormal      (surfaceNormal),
      .surfaceLightVector (surfaceLightVector),
      .m_axis_tdata       (m_axis_tdata),
      .m_axis_tvalid      (m_axis_tvalid),
      .m_axis_tready      (m_axis_tready),
      .m_axis_tuser       (m_axis_tuser),
      .m_axis_tlast       (m_axis_tlast)
   );

   always #5 clk = ~clk;

   // reference shading in wide integer arithmetic
   function automatic logic [23:0] model(input logic h, input logic [95:0] n, input logic [95:0] l);
      longint d, it, a, b;
      logic [23:0] r;
      logic [23:0] base;
      base = 24'hFF8040;
      d = 0;
      for (int i = 0; i < 3; i++) begin
         a = longint'($signed(n[i*32 +: 32]));
         b = longint'($signed(l[i*32 +: 32]));
         d += (a * b) >>> 24;
      end
      if (d < 0) d = 0;
      if (d > 64'sd16777216) d = 64'sd16777216;
      it = 64'sd4194304 + ((64'sd12582912 * d) >>> 24);
      if (it < 0) it = 0;
      if (it > 64'sd16777216) it = 64'sd16777216;
      for (int c = 0; c < 3; c++)
         r[c*8 +: 8] = 8'((longint'(base[c*8 +: 8]) * it) >>> 24);
      return h ? r : 24'h000000;
   endfunction

   function automatic logic [31:0] rcomp();
      return 32'($urandom_range(0, 32'h02000000)) - ONE;
   endfunction

   task automatic fill_random(input int n);
      for (int i = 0; i < n; i++) begin
         pn[i] = {rcomp(), rcomp(), rcomp()};
         pl[i] = {rcomp(), rcomp(), rcomp()};
         ph[i] = ($urandom_range(0, 3) != 0);
         pe[i] = model(ph[i], pn[i], pl[i]);
      end
   endtask

   task automatic drive_pix(input int idx);
      valid_in           = 1'b1;
      hit                = ph[idx];
      surfaceNormal      = pn[idx];
      surfaceLightVector = pl[idx];
      exp_in             = pe[idx];
   endtask

   // scoreboard: push at acceptance, pop and compare at output handshake
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            sb_q.delete();
            bx = 0;
            by = 0;
         end else begin
            if (valid_in && ready_in)
               sb_q.push_back(exp_in);
            if (m_axis_tvalid && m_axis_tready) begin
               compared++;
               if (sb_q.size() == 0) begin
                  mismatched++;
                  $display("FAIL sb_underflow: beat %h with nothing expected", m_axis_tdata);
               end else begin
                  logic [23:0] e;
                  e = sb_q.pop_front();
                  if (m_axis_tdata !== e) begin
                     mismatched++;
                     $display("FAIL sb_tdata: got %h expected %h", m_axis_tdata, e);
                  end
               end
               compared++;
               if (m_axis_tuser !== (bx == 0 && by == 0)) begin
                  mismatched++;
                  $display("FAIL sb_tuser: got %b expected %b at x=%0d y=%0d", m_axis_tuser, (bx == 0 && by == 0), bx, by);
               end
               compared++;
               if (m_axis_tlast !== (bx == H - 1)) begin
                  mismatched++;
                  $display("FAIL sb_tlast: got %b expected %b at x=%0d y=%0d", m_axis_tlast, (bx == H - 1), bx, by);
               end
               $display("beat x=%0d y=%0d tdata=%h tuser=%b tlast=%b", bx, by, m_axis_tdata, m_axis_tuser, m_axis_tlast);
               if (bx == H - 1) begin
                  bx = 0;
                  by = (by == V - 1) ? 0 : by + 1;
               end else begin
                  bx = bx + 1;
               end
            end
         end
      end
   end

   task automatic do_reset();
      valid_in = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic stream(input int first, input int n);
      int idx = first;
      int cyc = 0;
      logic acc;
      m_axis_tready = 1'b1;
      while (idx < first + n && cyc < 100) begin
         drive_pix(idx);
         @(negedge clk);
         acc = valid_in && ready_in;
         @(posedge clk); #1;
         if (acc) idx++;
         cyc++;
      end
      valid_in = 1'b0;
      compared++;
      if (idx !== first + n) begin
         mismatched++;
         $display("FAIL stream_timeout: accepted %0d required %0d", idx - first, n);
      end
   endtask

   task automatic drain();
      int cyc = 0;
      m_axis_tready = 1'b1;
      while (sb_q.size() != 0 && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      compared++;
      if (sb_q.size() != 0) begin
         mismatched++;
         $display("FAIL drain: %0d beats outstanding required 0", sb_q.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      valid_in = 1'b0;
      m_axis_tready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      compared++; if (m_axis_tvalid !== 1'b0) begin mismatched++; $display("FAIL reset_tvalid: got %b required 0", m_axis_tvalid); end
      compared++; if (m_axis_tdata !== 24'h0) begin mismatched++; $display("FAIL reset_tdata: got %h required 000000", m_axis_tdata); end
      compared++; if (m_axis_tuser !== 1'b0) begin mismatched++; $display("FAIL reset_tuser: got %b required 0", m_axis_tuser); end
      compared++; if (m_axis_tlast !== 1'b0) begin mismatched++; $display("FAIL reset_tlast: got %b required 0", m_axis_tlast); end
      compared++; if (ready_in !== 1'b0) begin mismatched++; $display("FAIL reset_ready: got %b required 0", ready_in); end
      rst_n = 1'b1;
      $display("reset checked");
   endtask

   task automatic test_known();
      pn[0] = {ONE, 32'h0, 32'h0};  pl[0] = {ONE, 32'h0, 32'h0}; ph[0] = 1'b1; pe[0] = 24'hFF8040;
      pn[1] = {32'h0, ONE, 32'h0};  pl[1] = {ONE, 32'h0, 32'h0}; ph[1] = 1'b1; pe[1] = 24'h3F2010;
      pn[2] = {NEG, 32'h0, 32'h0};  pl[2] = {ONE, 32'h0, 32'h0}; ph[2] = 1'b1; pe[2] = 24'h3F2010;
      pn[3] = {rcomp(), rcomp(), rcomp()}; pl[3] = {rcomp(), rcomp(), rcomp()}; ph[3] = 1'b0; pe[3] = 24'h000000;
      m_axis_tready = 1'b1;
      @(posedge clk); #1;
      drive_pix(0);
      @(negedge clk);
      @(posedge clk); #1;          // accepted on this edge
      valid_in = 1'b0;
      @(posedge clk); #1;
      compared++; if (m_axis_tvalid !== 1'b0) begin mismatched++; $display("FAIL latency_early: tvalid %b required 0", m_axis_tvalid); end
      @(posedge clk); #1;
      compared++; if (m_axis_tvalid !== 1'b1) begin mismatched++; $display("FAIL latency: tvalid %b required 1", m_axis_tvalid); end
      compared++; if (m_axis_tdata !== 24'hFF8040) begin mismatched++; $display("FAIL latency_tdata: got %h required FF8040", m_axis_tdata); end
      stream(1, 3);
      drain();
      $display("known vectors done");
   endtask

   task automatic test_frame();
      int idx = 0;
      int beat = 0;
      int cyc = 0;
      logic acc;
      do_reset();
      fill_random(9);
      m_axis_tready = 1'b1;
      while (beat < 9 && cyc < 100) begin
         if (idx < 9) drive_pix(idx); else valid_in = 1'b0;
         @(negedge clk);
         acc = valid_in && ready_in;
         if (m_axis_tvalid && m_axis_tready) begin
            compared++;
            if (m_axis_tlast !== (beat % 4 == 3)) begin mismatched++; $display("FAIL frame_tlast: beat %0d got %b required %b", beat + 1, m_axis_tlast, (beat % 4 == 3)); end
            compared++;
            if (m_axis_tuser !== (beat == 0 || beat == 8)) begin mismatched++; $display("FAIL frame_tuser: beat %0d got %b required %b", beat + 1, m_axis_tuser, (beat == 0 || beat == 8)); end
            beat++;
         end
         @(posedge clk); #1;
         if (acc) idx++;
         cyc++;
      end
      valid_in = 1'b0;
      compared++;
      if (beat != 9 || cyc != 12) begin mismatched++; $display("FAIL frame_throughput: %0d beats in %0d cycles required 9 in 12", beat, cyc); end
      drain();
      $display("frame markers done");
   endtask

   task automatic test_stall();
      int idx = 0;
      int beat = 0;
      int cyc = 0;
      logic acc;
      logic held_valid = 1'b0;
      logic [23:0] held_data = '0;
      logic held_user = 1'b0;
      logic held_last = 1'b0;
      do_reset();
      fill_random(5);
      while (beat < 5 && cyc < 100) begin
         m_axis_tready = (cyc % 3 == 0);
         if (idx < 5) drive_pix(idx); else valid_in = 1'b0;
         @(negedge clk);
         acc = valid_in && ready_in;
         if (held_valid) begin
            compared++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== held_data || m_axis_tuser !== held_user || m_axis_tlast !== held_last) begin
               mismatched++;
               $display("FAIL stall_hold: got v=%b %h u=%b l=%b required v=1 %h u=%b l=%b", m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, held_data, held_user, held_last);
            end
         end
         if (m_axis_tvalid && !m_axis_tready) begin
            compared++;
            if (ready_in !== 1'b0) begin mismatched++; $display("FAIL stall_ready: got %b required 0", ready_in); end
            held_valid = 1'b1;
            held_data  = m_axis_tdata;
            held_user  = m_axis_tuser;
            held_last  = m_axis_tlast;
         end else begin
            held_valid = 1'b0;
         end
         if (m_axis_tvalid && m_axis_tready) beat++;
         @(posedge clk); #1;
         if (acc) idx++;
         cyc++;
      end
      valid_in = 1'b0;
      compared++;
      if (beat != 5) begin mismatched++; $display("FAIL stall_timeout: %0d beats required 5", beat); end
      drain();
      $display("stall stream done");
   endtask

   task automatic test_reset_mid();
      int idx = 0;
      int beat = 0;
      int cyc = 0;
      logic acc;
      do_reset();
      fill_random(8);
      m_axis_tready = 1'b1;
      while (beat < 3 && cyc < 100) begin
         drive_pix(idx);
         @(negedge clk);
         acc = valid_in && ready_in;
         if (m_axis_tvalid && m_axis_tready) beat++;
         @(posedge clk); #1;
         if (acc) idx++;
         cyc++;
      end
      valid_in = 1'b0;
      rst_n = 1'b0;
      #1;
      compared++; if (m_axis_tvalid !== 1'b0) begin mismatched++; $display("FAIL midreset_tvalid: got %b required 0", m_axis_tvalid); end
      compared++; if (ready_in !== 1'b0) begin mismatched++; $display("FAIL midreset_ready: got %b required 0", ready_in); end
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      pn[10] = {32'h0, 32'h0, ONE}; pl[10] = {32'h0, 32'h0, ONE}; ph[10] = 1'b1; pe[10] = 24'hFF8040;
      stream(10, 1);
      cyc = 0;
      while (m_axis_tvalid !== 1'b1 && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      compared++; if (m_axis_tuser !== 1'b1) begin mismatched++; $display("FAIL midreset_tuser: got %b required 1", m_axis_tuser); end
      compared++; if (m_axis_tlast !== 1'b0) begin mismatched++; $display("FAIL midreset_tlast: got %b required 0", m_axis_tlast); end
      drain();
      $display("mid-frame reset done");
   endtask

   initial begin
      test_reset();
      test_known();
      test_frame();
      test_stall();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/lambert_shade_stream.md
Name: lambert_shade_stream

Overview:
- Consumer of the surface-vector stage.
- Takes a unit surface normal and a unit surface-to-light vector per pixel, computes Lambertian diffuse intensity with ambient term, and scales a fixed base colour into RGB888.
- Emits pixels as an AXI4-Stream video beat stream with frame/line markers toward the framebuffer/VDMA.
- 3-stage valid/ready pipeline with full backpressure.

Parameters:
- H_RES, 640, pixels per line (tlast position)
- V_RES, 480, lines per frame (tuser wrap)
- AMBIENT, 32'h00400000, ambient intensity, Q8.24 (0.25)
- KD, 32'h00C00000, diffuse coefficient, Q8.24 (0.75)
- BASE_RGB, 24'hFF8040, surface colour {R,G,B}
- BG_RGB, 24'h000000, colour for rays that missed

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- valid_in  in  1  input pixel valid
- ready_in  out  1  block can accept input this cycle
- hit  in  1  1 = ray hit surface, 0 = miss (vectors ignored)
- surfaceNormal  in  96  vec3 {x[95:64],y[63:32],z[31:0]}, each signed Q8.24
- surfaceLightVector  in  96  vec3, same packing
- m_axis_tdata  out  24  {R[23:16],G[15:8],B[7:0]}
- m_axis_tvalid  out  1  output beat valid
- m_axis_tready  in  1  downstream ready
- m_axis_tuser  out  1  start of frame (x==0,y==0)
- m_axis_tlast  out  1  end of line (x==H_RES-1)

Behaviour:
- Reset (rst_n low, async): all stage valids 0, m_axis_tvalid 0, tdata 0, tuser 0, tlast 0, x/y counters 0. ready_in = 0 while rst_n low.
- Pipeline enable: en = !m_axis_tvalid || m_axis_tready. ready_in = en. All stages advance together only when en=1. Input accepted when valid_in && ready_in.
- Latency: accepted input appears on m_axis_* exactly 3 cycles later when never stalled. Throughput 1 pixel/cycle.
- Stalls: with m_axis_tvalid=1 and tready=0, tdata/tuser/tlast hold stable and no stage changes. Bubbles (valid 0) propagate as valid 0 and do not advance counters.
- fp_mul rule: signed 32x32 -> 64-bit product, result = product[55:24] (truncation toward -inf).
- S1: register the three products nx*lx, ny*ly, nz*lz (fp_mul), plus hit.
- S2: diff = sign-extended 34-bit sum of the three products; clamp to [0, 32'h01000000]. intensity = AMBIENT + fp_mul(KD, diff_clamped), computed in 34 bits; clamp to [0, 32'h01000000].
- S3: per channel c = (BASE_c[7:0] * intensity[24:0]) >> 24 (33-bit product; intensity=1.0 yields exactly BASE_c, max 255). If hit=0, tdata = BG_RGB regardless of vectors.
- Counters x (0..H_RES-1), y (0..V_RES-1) label the beat currently on the output. Advance only on handshake (tvalid && tready): x wraps H_RES-1 -> 0 with y+1; y wraps V_RES-1 -> 0.
- tuser = (x==0 && y==0); tlast = (x==H_RES-1). Both are combinational from counters, qualified by tvalid (0 when tvalid=0).
- Non-unit or degenerate inputs (e.g. zero vector): no special handling; the clamp guarantees output in range.
- Reset mid-frame: in-flight pixels discarded, next output beat is tuser=1.

Test Plan:
- n=(1,0,0) [x=32'h01000000], l=(1,0,0), hit=1, tready=1 -> 3 cycles later tdata=24'hFF8040, tuser=1, tlast=0.
- n=(0,1,0), l=(1,0,0), hit=1 -> diff=0, intensity=0.25 -> tdata=24'h3F2010. Also n=(-1,0,0), l=(1,0,0) -> diff clamps to 0 -> tdata=24'h3F2010.
- hit=0 with arbitrary vectors -> tdata=24'h000000.
- H_RES=4, V_RES=2: stream 9 pixels continuously -> tlast on beats 4 and 8, tuser on beats 1 and 9.
- Stream 5 pixels with tready toggling 1,0,0,1,... -> no pixel lost or duplicated. tdata stable while stalled. ready_in low during stall cycles with tvalid=1. Output order matches input order.
- Assert rst_n low for 1 cycle after 3 of 4 pixels of a line are output -> tvalid=0 immediately. After reset, next output beat has tuser=1 and x restarts at 0.
